// File: rtl/fpalu_pkg.sv
// Shared constants and FSM encoding for the single-precision FP ALU datapath.
// The raw significand layout is [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky.
package fpalu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = FRAC_W + 4;

    localparam int CARRY  = 26;
    localparam int HIDDEN = 25;
    localparam int GUARD  = 1;
    localparam int STICKY = 0;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/fpalu_rne.sv
// Round-to-nearest-even increment on the raw significand.
// Produces hidden+fraction (sig_o) and the carry out of the increment.
module fpalu_rne
    import fpalu_pkg::*;
(
    input  logic [SIG_W-1:0]  sig_i,
    output logic [FRAC_W:0]   sig_o,
    output logic              carry_o
);

    logic          round_up;
    logic [FRAC_W+1:0] sum;

    // Ties go up only when the kept LSB is odd.
    assign round_up = sig_i[GUARD] & (sig_i[STICKY] | sig_i[GUARD+1]);
    assign sum      = sig_i[CARRY:GUARD+1] + {{(FRAC_W+1){1'b0}}, round_up};
    assign sig_o    = sum[FRAC_W:0];
    assign carry_o  = sum[FRAC_W+1];

endmodule

// File: rtl/fpalu_norm_round.sv
// Post-add normalize-and-round stage: renormalizes the raw adder sum one bit
// per cycle, rounds RNE and packs a binary32 result with overflow/inexact/zero flags.
module fpalu_norm_round
    import fpalu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_inexact,
    output logic             out_zero,
    output state_t           dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; out_valid and all outputs stay frozen until out_ready, and no new
    // input is taken until the cycle after the output transfer.

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               inx_q, inx_d;
    logic               zero_q, zero_d;

    logic [SIG_W-1:0]   renorm_sig, norm_sig;
    logic [EXP_W-1:0]   exp_inc, norm_exp, rnd_exp, rnd_field;
    logic [FRAC_W:0]    rnd_sig;
    logic               rnd_carry, rnd_hidden;
    logic [FRAC_W-1:0]  rnd_frac;

    assign renorm_sig = {1'b0, sig_q[CARRY:GUARD+1], sig_q[GUARD] | sig_q[STICKY]};
    assign exp_inc    = exp_q + EXP_W'(1);
    assign norm_sig   = {sig_q[SIG_W-2:0], 1'b0} | {{(SIG_W-1){1'b0}}, sig_q[STICKY]};
    assign norm_exp   = exp_q - EXP_W'(1);

    fpalu_rne u_rne (
        .sig_i   (sig_q),
        .sig_o   (rnd_sig),
        .carry_o (rnd_carry)
    );

    // A carry out of rounding means the significand became 10.000...; shift right once.
    assign rnd_exp    = exp_q + {{(EXP_W-1){1'b0}}, rnd_carry};
    assign rnd_hidden = rnd_carry | rnd_sig[FRAC_W];
    assign rnd_frac   = rnd_carry ? rnd_sig[FRAC_W:1] : rnd_sig[FRAC_W-1:0];
    assign rnd_field  = !rnd_hidden         ? '0 :
                        (rnd_exp == '0)     ? EXP_W'(1) : rnd_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_CHECK;
            ST_CHECK: begin
                if (exp_q == EXP_MAX || sig_q == '0)          state_d = ST_OUT;
                else if (sig_q[CARRY])                        state_d = (exp_inc == EXP_MAX) ? ST_OUT : ST_ROUND;
                else if (!sig_q[HIDDEN] && exp_q > EXP_W'(1)) state_d = ST_NORM;
                else                                          state_d = ST_ROUND;
            end
            ST_NORM:  if (norm_sig[HIDDEN] || norm_exp == EXP_W'(1)) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_OUT;
            ST_OUT:   if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_OUT);
        dbg_state = state_q;
    end

    always_comb begin
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        inx_d    = inx_q;
        zero_d   = zero_q;
        unique case (state_q)
            ST_IDLE: if (in_valid) begin
                sign_d   = in_sign;
                exp_d    = in_exp;
                sig_d    = in_sig;
                result_d = '0;
                ovf_d    = 1'b0;
                inx_d    = 1'b0;
                zero_d   = 1'b0;
            end
            ST_CHECK: begin
                if (exp_q == EXP_MAX) begin
                    result_d = {sign_q, EXP_MAX, sig_q[HIDDEN-1:GUARD+1]};
                end else if (sig_q == '0) begin
                    zero_d = 1'b1;
                end else if (sig_q[CARRY]) begin
                    sig_d = renorm_sig;
                    exp_d = exp_inc;
                    if (exp_inc == EXP_MAX) begin
                        result_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                        ovf_d    = 1'b1;
                        inx_d    = renorm_sig[GUARD] | renorm_sig[STICKY];
                    end
                end else if (exp_q == '0 && sig_q[HIDDEN]) begin
                    exp_d = EXP_W'(1);
                end
            end
            ST_NORM: begin
                sig_d = norm_sig;
                exp_d = norm_exp;
            end
            ST_ROUND: begin
                inx_d = sig_q[GUARD] | sig_q[STICKY];
                if (rnd_exp == EXP_MAX) begin
                    result_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, rnd_field, rnd_frac};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sig_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            inx_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sig_q    <= sig_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            inx_q    <= inx_d;
            zero_q   <= zero_d;
        end
    end

    assign out_result   = result_q;
    assign out_overflow = ovf_q;
    assign out_inexact  = inx_q;
    assign out_zero     = zero_q;

endmodule

// File: tb/tb_fpalu_norm_round.sv
// Self-checking bench for fpalu_norm_round: directed corner cases plus random exact normals.
module tb_fpalu_norm_round;
    import fpalu_pkg::*;

    localparam int W = 35;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sign = 1'b0;
    logic [EXP_W-1:0] in_exp = '0;
    logic [SIG_W-1:0] in_sig = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic             out_overflow;
    logic             out_inexact;
    logic             out_zero;
    state_t           dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    fpalu_norm_round dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_sig       (in_sig),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_inexact  (out_inexact),
        .out_zero     (out_zero),
        .dbg_state    (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // driver: one input transfer, expected {result, overflow, inexact, zero} queued
    task automatic drive(input logic s, input logic [EXP_W-1:0] e, input logic [SIG_W-1:0] sg,
                         input logic [31:0] res, input logic ovf, input logic inx, input logic zr);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_drive", W'(in_ready), W'(1));
        exp_q.push_back({res, ovf, inx, zr});
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_sig   = sg;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // scoreboard: wait for out_valid, check latency (lat < 0 skips it), compare against queue head
    task automatic collect(input string tag, input int lat);
        int n = 0;
        logic [W-1:0] want;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_valid"}, W'(out_valid), W'(1));
        if (lat >= 0) check({tag, "_latency"}, W'(n), W'(lat));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check(tag, {out_result, out_overflow, out_inexact, out_zero}, want);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [EXP_W-1:0]  re;
        logic [FRAC_W-1:0] rf;
        logic              rs;

        // reset block
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_result", W'(out_result), W'(0));
        check("reset_flags", W'({out_overflow, out_inexact, out_zero}), W'(0));
        check("reset_state", W'(dbg_state), W'(ST_IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        // 1.0 + 1.0 = 2.0 via carry renormalization
        drive(1'b0, 8'h7F, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 1'b0);
        collect("one_plus_one", 2);
        release_out();

        // cancellation: two left shifts
        drive(1'b0, 8'h7F, 27'h0800000, 32'h3E800000, 1'b0, 1'b0, 1'b0);
        collect("cancel", 4);
        release_out();

        // sticky carried through NORM then rounds up
        drive(1'b0, 8'h7F, 27'h0800001, 32'h3E800002, 1'b0, 1'b1, 1'b0);
        collect("cancel_sticky", 4);
        release_out();

        // RNE ties: even stays, odd rounds up
        drive(1'b0, 8'h7F, 27'h2000002, 32'h3F800000, 1'b0, 1'b1, 1'b0);
        collect("tie_even", 2);
        release_out();
        drive(1'b0, 8'h7F, 27'h2000006, 32'h3F800002, 1'b0, 1'b1, 1'b0);
        collect("tie_odd", 2);
        release_out();

        // negative -3.0
        drive(1'b1, 8'h80, 27'h3000000, 32'hC0400000, 1'b0, 1'b0, 1'b0);
        collect("neg_three", 2);
        release_out();

        // overflow from carry renormalization and from rounding
        drive(1'b0, 8'hFE, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 1'b0);
        collect("ovf_carry", -1);
        release_out();
        drive(1'b0, 8'hFE, 27'h3FFFFFE, 32'h7F800000, 1'b1, 1'b1, 1'b0);
        collect("ovf_round", 2);
        release_out();

        // Inf/NaN passthrough
        drive(1'b1, 8'hFF, 27'h2400000, 32'hFF900000, 1'b0, 1'b0, 1'b0);
        collect("nan_pass", -1);
        release_out();

        // denormals: plain, NORM stopping at exp 1, rounding up into min normal
        drive(1'b0, 8'h01, 27'h1000000, 32'h00400000, 1'b0, 1'b0, 1'b0);
        collect("denorm", 2);
        release_out();
        drive(1'b0, 8'h03, 27'h0400000, 32'h00400000, 1'b0, 1'b0, 1'b0);
        collect("denorm_norm_floor", 4);
        release_out();
        drive(1'b0, 8'h01, 27'h1FFFFFE, 32'h00800000, 1'b0, 1'b1, 1'b0);
        collect("denorm_round_up", 2);
        release_out();

        // zero result with backpressure and an ignored input during OUT
        drive(1'b1, 8'h40, 27'h0000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        collect("zero", -1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_exp   = 8'h7F;
            in_sig   = 27'h4000000;
            @(posedge clk); #1;
            check("bp_valid", W'(out_valid), W'(1));
            check("bp_in_ready", W'(in_ready), W'(0));
            check("bp_hold", {out_result, out_overflow, out_inexact, out_zero}, W'(1));
        end
        in_valid = 1'b0;
        release_out();
        check("bp_release_in_ready", W'(in_ready), W'(1));
        check("bp_release_valid", W'(out_valid), W'(0));

        // random exact normals
        for (int i = 0; i < 8; i++) begin
            re = EXP_W'($urandom_range(1, 254));
            rf = FRAC_W'($urandom_range(0, 32'h7FFFFF));
            rs = 1'($urandom_range(0, 1));
            drive(rs, re, {2'b01, rf, 2'b00}, {rs, re, rf}, 1'b0, 1'b0, 1'b0);
            collect("rand_normal", 2);
            release_out();
        end

        // reset in the middle of NORM
        drive(1'b0, 8'h7F, 27'h0000004, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_state", W'(dbg_state), W'(ST_NORM));
        rst = 1'b1;
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 8'h7F, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 1'b0);
        collect("post_rst_one_plus_one", 2);
        release_out();

        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
